// File: rtl/exu_wb_arb.sv
// EXU writeback arbiter: merges ALU, LSU, MUL and DIV results into one registered
// register-file write port, buffering the multi-cycle sources in small FIFOs.

module exu_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic          o_ready,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_valid & ~w_full;
  assign o_ready = ~w_full;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(i_pop);
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_valid && w_full))
    else $error("result presented to a full writeback FIFO was dropped");
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && r_count == '0))
    else $error("writeback FIFO popped while empty");

endmodule

module exu_wb_arb #(
  parameter int XLEN                = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH          = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_wb_valid,
  input  logic [XLEN-1:0]                alu_wb_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_wb_rd_addr,
  input  logic                           mul_wb_valid,
  input  logic [XLEN-1:0]                mul_wb_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mul_wb_rd_addr,
  output logic                           mul_wb_ready,
  input  logic                           div_wb_valid,
  input  logic [XLEN-1:0]                div_wb_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr,
  output logic                           div_wb_ready,
  input  logic                           lsu_wb_valid,
  input  logic [XLEN-1:0]                lsu_wb_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] lsu_wb_rd_addr,
  output logic                           lsu_wb_ready,
  output logic [XLEN-1:0]                exu_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr,
  output logic                           exu_wb_rd_wr_en,
  output logic                           mul_wb_pending,
  output logic                           div_wb_pending,
  output logic                           lsu_wb_pending,
  output logic                           wb_stall
);

  localparam int EW = REG_FILE_ADDR_WIDTH + XLEN;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 1);

  logic [EW-1:0] w_mul_head, w_div_head, w_lsu_head;
  logic [CW-1:0] w_mul_count, w_div_count, w_lsu_count;
  logic          w_mul_pop, w_div_pop, w_lsu_pop;
  logic          w_win_valid;
  logic [EW-1:0] w_win_entry;

  logic [XLEN-1:0]                r_wb_data;
  logic [REG_FILE_ADDR_WIDTH-1:0] r_wb_rd_addr;
  logic                           r_wb_rd_wr_en;

  exu_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_mul_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_valid (mul_wb_valid),
    .i_data  ({mul_wb_rd_addr, mul_wb_data}),
    .i_pop   (w_mul_pop),
    .o_ready (mul_wb_ready),
    .o_head  (w_mul_head),
    .o_count (w_mul_count)
  );

  exu_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_div_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_valid (div_wb_valid),
    .i_data  ({div_wb_rd_addr, div_wb_data}),
    .i_pop   (w_div_pop),
    .o_ready (div_wb_ready),
    .o_head  (w_div_head),
    .o_count (w_div_count)
  );

  exu_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_lsu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_valid (lsu_wb_valid),
    .i_data  ({lsu_wb_rd_addr, lsu_wb_data}),
    .i_pop   (w_lsu_pop),
    .o_ready (lsu_wb_ready),
    .o_head  (w_lsu_head),
    .o_count (w_lsu_count)
  );

  assign mul_wb_pending = (w_mul_count != '0);
  assign div_wb_pending = (w_div_count != '0);
  assign lsu_wb_pending = (w_lsu_count != '0);

  // One slot of margin covers the result already issued when decode sees the stall.
  assign wb_stall = (w_mul_count >= STALL_LVL) | (w_div_count >= STALL_LVL) |
                    (w_lsu_count >= STALL_LVL);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_entry = '0;
    w_lsu_pop   = 1'b0;
    w_mul_pop   = 1'b0;
    w_div_pop   = 1'b0;
    if (alu_wb_valid) begin
      w_win_valid = 1'b1;
      w_win_entry = {alu_wb_rd_addr, alu_wb_data};
    end else if (lsu_wb_pending) begin
      w_win_valid = 1'b1;
      w_win_entry = w_lsu_head;
      w_lsu_pop   = 1'b1;
    end else if (mul_wb_pending) begin
      w_win_valid = 1'b1;
      w_win_entry = w_mul_head;
      w_mul_pop   = 1'b1;
    end else if (div_wb_pending) begin
      w_win_valid = 1'b1;
      w_win_entry = w_div_head;
      w_div_pop   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_data     <= '0;
      r_wb_rd_addr  <= '0;
      r_wb_rd_wr_en <= 1'b0;
    end else begin
      // x0 results are consumed but never written.
      r_wb_rd_wr_en <= w_win_valid && (w_win_entry[EW-1:XLEN] != '0);
      if (w_win_valid) begin
        r_wb_data    <= w_win_entry[XLEN-1:0];
        r_wb_rd_addr <= w_win_entry[EW-1:XLEN];
      end
    end
  end

  assign exu_wb_data     = r_wb_data;
  assign exu_wb_rd_addr  = r_wb_rd_addr;
  assign exu_wb_rd_wr_en = r_wb_rd_wr_en;

endmodule
